alu_shift_sequencer: RTL
========================

// Module: alu_shift_sequencer
// PURPOSE
//  Multi-bit shift/rotate controller for the 32-bit ArithmeticLogicUnit, whose shift ops move one bit per use.
//  Accepts a shift command (op, amount, operand), steps the ALU once per cycle with WF high, and feeds ALUOut back as the next A.
//  Returns the final value plus the ALU flags {Z,C,N,O} after the last step.
//  Sits between the control unit and the ALU A/FunSel/WF inputs.
// PARAMETERS
//  DATA_WIDTH   32  operand/result width; only 32 is supported (matches ALU)
//  SHAMT_WIDTH  5   shift-amount width; amounts 0..31
// PORTS
//  Clock        in   1   rising-edge clock
//  Reset        in   1   synchronous, active-high reset
//  StartValid   in   1   command valid
//  StartReady   out  1   high only in IDLE; a command is accepted on StartValid & StartReady
//  Op           in   3   000 LSL, 001 LSR, 010 ASR, 011 CSL, 100 CSR; 101-111 illegal
//  ShAmt        in   5   number of one-bit steps
//  Operand      in   32  value to shift
//  ALU_A        out  32  to ALU A (working register)
//  ALU_FunSel   out  5   to ALU FunSel; {1'b1, code}: LSL 1011, LSR 1100, ASR 1101, CSL 1110, CSR 1111
//  ALU_WF       out  1   to ALU WF
//  ALU_Out      in   32  from ALU ALUOut
//  ALU_Flags    in   4   from ALU FlagsOut {Z,C,N,O}
//  Result       out  32  final value; held until the next Done
//  ResultFlags  out  4   ALU_Flags captured after the last step
//  Done         out  1   one-cycle completion pulse
//  Error        out  1   pulses with Done on an illegal Op
// BEHAVIOUR
//  Reset values: state IDLE, work 0, count 0, Result 0, ResultFlags 0, Done 0, Error 0.
//  StartReady=1 immediately after reset (derived from IDLE).
//  States are IDLE, SHIFT, FLAG and DONE; all outputs are decoded from registered state.
//  IDLE: StartReady=1.
//   - On accept, latch work<=Operand, op and count<=ShAmt.
//   - Illegal op -> DONE with Error: Result<=Operand, ResultFlags<=ALU_Flags.
//   - ShAmt==0 -> DONE: Result<=Operand, ResultFlags<=ALU_Flags, ALU untouched.
//   - Otherwise -> SHIFT.
//  SHIFT: ALU_A=work, ALU_FunSel={1,code}, ALU_WF=1. Every cycle: work<=ALU_Out, count<=count-1.
//   - When count==1 at the edge, go to FLAG.
//   - WF is high every step so CSL/CSR see the carry updated by the previous step.
//  FLAG: ALU_WF=0. ALU flags now reflect the last step. Result<=work, ResultFlags<=ALU_Flags; go to DONE.
//  DONE: Done=1 (Error=1 if illegal) for exactly one cycle; StartReady=0; go to IDLE.
//  Outside SHIFT: ALU_WF=0, ALU_FunSel=5'b10000 (pass A), ALU_A=work.
//  Latency, accept edge to Done cycle: ShAmt+2 cycles for ShAmt>=1; 1 cycle for ShAmt==0 or illegal op.
//  ALU_WF is high for exactly ShAmt cycles per command.
//  StartValid outside IDLE is ignored (no queueing). Back-to-back commands: next accept is the cycle after DONE.
//  Reset mid-operation: IDLE at the next edge, no Done, Result/ResultFlags cleared.
//   - The ALU flags may already hold partially updated values; the controller does not restore them.
//  The count is 5 bits and never wraps; ShAmt=31 runs 31 steps.
// CONFIGURATION
//  ALU_SEQ_ABORT_EN defined: adds input Abort (1 bit).
//   - Abort high in SHIFT or FLAG -> IDLE at the next edge; no Done; Result/ResultFlags unchanged.
//   - Abort in IDLE or DONE is ignored. Reset has priority over Abort.
//  ALU_SEQ_ABORT_EN undefined: no Abort port; a command always runs to DONE unless Reset.
// TESTING
//  The bench drives ALU_Out/ALU_Flags from a one-bit-shift ALU model that follows the FunSel encoding above.
//  T1: reset; LSL 0x0000_0001 by 4 -> Done 6 cycles after accept; Result 0x0000_0010; Z=0 C=0 N=0; WF high 4 cycles.
//  T2: ASR 0x8000_0000 by 31 -> Result 0xFFFF_FFFF; N=1; Done 33 cycles after accept.
//  T3: LSR 0x1234_5678 by 0 -> Done 1 cycle after accept; Result 0x1234_5678; WF never high.
//  T4: Op=110, Operand 0xDEAD_BEEF -> Done and Error together 1 cycle after accept; Result 0xDEAD_BEEF.
//  T5: LSR by 10 with Reset on the 3rd SHIFT cycle -> IDLE next edge; no Done; StartReady=1; Result 0.
//  T6 (ALU_SEQ_ABORT_EN): CSR by 8, Abort on step 2 -> no Done; prior Result kept; a new command is accepted the next cycle.

Source files
------------

// File: rtl/alu_shift_sequencer.sv
// Multi-bit shift/rotate sequencer that steps a one-bit-per-use ALU shifter once per cycle.
// Optional Abort input is enabled by defining ALU_SEQ_ABORT_EN.
module alu_shift_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic                   Clock,
  input  logic                   Reset,
`ifdef ALU_SEQ_ABORT_EN
  input  logic                   Abort,
`endif
  input  logic                   StartValid,
  output logic                   StartReady,
  input  logic [2:0]             Op,
  input  logic [SHAMT_WIDTH-1:0] ShAmt,
  input  logic [DATA_WIDTH-1:0]  Operand,
  output logic [DATA_WIDTH-1:0]  ALU_A,
  output logic [4:0]             ALU_FunSel,
  output logic                   ALU_WF,
  input  logic [DATA_WIDTH-1:0]  ALU_Out,
  input  logic [3:0]             ALU_Flags,
  output logic [DATA_WIDTH-1:0]  Result,
  output logic [3:0]             ResultFlags,
  output logic                   Done,
  output logic                   Error
);

  localparam int unsigned OP_WIDTH   = 3;
  localparam int unsigned FLAG_WIDTH = 4;
  localparam logic [4:0]  FUNSEL_PASS_A = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FLAG  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   work_q, work_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [SHAMT_WIDTH-1:0]  count_q, count_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [FLAG_WIDTH-1:0]   rflags_q, rflags_d;

  logic                    accept_c;
  logic                    op_legal_c;
  logic                    abort_c;
  logic [3:0]              shift_code_c;

`ifdef ALU_SEQ_ABORT_EN
  assign abort_c = Abort;
`else
  assign abort_c = 1'b0;
`endif

  assign accept_c   = StartValid && (state_q == ST_IDLE);
  assign op_legal_c = (Op <= 3'd4);

  // ALU shift function code for the latched op (low four FunSel bits)
  always_comb begin
    shift_code_c = 4'b0000;
    case (op_q)
      3'd0:    shift_code_c = 4'b1011;
      3'd1:    shift_code_c = 4'b1100;
      3'd2:    shift_code_c = 4'b1101;
      3'd3:    shift_code_c = 4'b1110;
      3'd4:    shift_code_c = 4'b1111;
      default: shift_code_c = 4'b0000;
    endcase
  end

  // State register and datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      op_q     <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      rflags_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      op_q     <= op_d;
      count_q  <= count_d;
      err_q    <= err_d;
      result_q <= result_d;
      rflags_q <= rflags_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    op_d     = op_q;
    count_d  = count_q;
    err_d    = err_q;
    result_d = result_q;
    rflags_d = rflags_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          work_d  = Operand;
          op_d    = Op;
          count_d = ShAmt;
          err_d   = !op_legal_c;
          if (!op_legal_c || (ShAmt == '0)) begin
            result_d = Operand;
            rflags_d = ALU_Flags;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (abort_c) begin
          state_d = ST_IDLE;
        end else begin
          work_d  = ALU_Out;
          count_d = count_q - SHAMT_WIDTH'(1);
          if (count_q == SHAMT_WIDTH'(1)) begin
            state_d = ST_FLAG;
          end
        end
      end

      // ALU flags now hold the outcome of the final step
      ST_FLAG: begin
        if (abort_c) begin
          state_d = ST_IDLE;
        end else begin
          result_d = work_q;
          rflags_d = ALU_Flags;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    StartReady = 1'b0;
    ALU_A      = work_q;
    ALU_FunSel = FUNSEL_PASS_A;
    ALU_WF     = 1'b0;
    Done       = 1'b0;
    Error      = 1'b0;
    case (state_q)
      ST_IDLE:  StartReady = 1'b1;
      ST_SHIFT: begin
        ALU_FunSel = {1'b1, shift_code_c};
        ALU_WF     = 1'b1;
      end
      ST_DONE: begin
        Done  = 1'b1;
        Error = err_q;
      end
      default: ;
    endcase
  end

  assign Result      = result_q;
  assign ResultFlags = rflags_q;

endmodule
